// File: rtl/lbm_sweep_controller_pkg.sv
// Shared definitions for the lattice-Boltzmann step sequencer: command word
// layout, FSM state encoding and the host read window helper.
package lbm_sweep_controller_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int RD_BIT     = DATA_WIDTH - 1;
  localparam int RUN_BIT    = DATA_WIDTH - 2;
  localparam int STEP_BIT   = DATA_WIDTH - 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_COLLIDE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  // Host may only read the macroscopic buffer while no write-back can occur.
  function automatic logic host_window(input state_e st);
    host_window = (st == ST_IDLE) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/lbm_gpio_cmd_decode.sv
// Decodes the GPIO command word: registered run level, step rising edge,
// and a range-checked host read request.
module lbm_gpio_cmd_decode
  import lbm_sweep_controller_pkg::*;
#(
  parameter int NODES = 400,
  parameter int IDX_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpio,
  output logic                  run,
  output logic                  step_req,
  output logic                  rd_req,
  output logic [IDX_W-1:0]      rd_idx
);

  localparam logic [IDX_W:0] NODES_L = (IDX_W + 1)'(NODES);

  logic run_r;
  logic step_cur_r;
  logic step_prev_r;
  logic gpio_unused_s;

  // Command bit sampling; step history feeds the edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r       <= 1'b0;
      step_cur_r  <= 1'b0;
      step_prev_r <= 1'b0;
    end else begin
      run_r       <= gpio[RUN_BIT];
      step_cur_r  <= gpio[STEP_BIT];
      step_prev_r <= step_cur_r;
    end
  end

  assign run      = run_r;
  assign step_req = step_cur_r & ~step_prev_r;

  // Read path stays combinational here; the top registers the grant.
  assign rd_idx        = gpio[IDX_W-1:0];
  assign rd_req        = gpio[RD_BIT] & ({1'b0, rd_idx} < NODES_L);
  assign gpio_unused_s = ^gpio[STEP_BIT-1:IDX_W];

endmodule

// File: rtl/lbm_sweep_controller.sv
// Lattice-Boltzmann step sequencer: stream, collide every node under
// ready/valid, drain the collider pipeline, then open a host read window.
module lbm_sweep_controller
  import lbm_sweep_controller_pkg::*;
#(
  parameter int NODES        = 400,
  parameter int IDX_W        = 9,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] GPIOi,
  output logic                  streamer_start,
  input  logic                  streamer_done,
  output logic                  collider_valid,
  output logic [IDX_W-1:0]      collider_idx,
  input  logic                  collider_ready,
  output logic                  in_collision_state,
  output logic                  host_rd_en,
  output logic [IDX_W-1:0]      host_rd_idx,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] step_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IDX_W-1:0]   LAST_NODE  = IDX_W'(NODES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e                state_r;
  state_e                next_state_s;
  logic [IDX_W-1:0]      node_cnt_r;
  logic [IDX_W-1:0]      node_cnt_next_s;
  logic [DRAIN_W-1:0]    drain_cnt_r;
  logic [DRAIN_W-1:0]    drain_cnt_next_s;
  logic [DATA_WIDTH-1:0] step_count_next_s;
  logic                  run_s;
  logic                  step_req_s;
  logic                  rd_req_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  start_req_s;

  lbm_gpio_cmd_decode #(
    .NODES (NODES),
    .IDX_W (IDX_W)
  ) u_cmd (
    .clk      (clk),
    .rst      (rst),
    .gpio     (GPIOi),
    .run      (run_s),
    .step_req (step_req_s),
    .rd_req   (rd_req_s),
    .rd_idx   (rd_idx_s)
  );

  assign start_req_s = run_s | step_req_s;

  // Next-state and counter update logic
  always_comb begin
    next_state_s      = state_r;
    node_cnt_next_s   = node_cnt_r;
    drain_cnt_next_s  = drain_cnt_r;
    step_count_next_s = step_count;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        next_state_s    = ST_STREAM;
        node_cnt_next_s = {IDX_W{1'b0}};
      end
      ST_STREAM: begin
        if (streamer_done) begin
          next_state_s = ST_COLLIDE;
        end else begin
          next_state_s = ST_STREAM;
        end
      end
      ST_COLLIDE: begin
        // Offer is always valid in this state, so ready alone means accepted.
        if (collider_ready) begin
          if (node_cnt_r == LAST_NODE) begin
            next_state_s     = ST_DRAIN;
            drain_cnt_next_s = DRAIN_LOAD;
          end else begin
            node_cnt_next_s = node_cnt_r + 1'b1;
          end
        end else begin
          node_cnt_next_s = node_cnt_r;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
          next_state_s      = ST_HOLD;
          step_count_next_s = step_count + 1'b1;
        end else begin
          drain_cnt_next_s = drain_cnt_r - 1'b1;
        end
      end
      ST_HOLD: begin
        if (start_req_s) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r            <= ST_IDLE;
      node_cnt_r         <= {IDX_W{1'b0}};
      drain_cnt_r        <= {DRAIN_W{1'b0}};
      step_count         <= {DATA_WIDTH{1'b0}};
      streamer_start     <= 1'b0;
      collider_valid     <= 1'b0;
      collider_idx       <= {IDX_W{1'b0}};
      in_collision_state <= 1'b0;
      busy               <= 1'b0;
      host_rd_en         <= 1'b0;
      host_rd_idx        <= {IDX_W{1'b0}};
    end else begin
      state_r            <= next_state_s;
      node_cnt_r         <= node_cnt_next_s;
      drain_cnt_r        <= drain_cnt_next_s;
      step_count         <= step_count_next_s;
      streamer_start     <= (next_state_s == ST_START);
      collider_valid     <= (next_state_s == ST_COLLIDE);
      collider_idx       <= (next_state_s == ST_COLLIDE) ? node_cnt_next_s : {IDX_W{1'b0}};
      in_collision_state <= (next_state_s == ST_COLLIDE) || (next_state_s == ST_DRAIN);
      busy               <= (next_state_s != ST_IDLE);
      // Gated by both sides of the transition so a grant never overlaps write-back.
      host_rd_en         <= rd_req_s & host_window(state_r) & host_window(next_state_s);
      host_rd_idx        <= rd_idx_s;
    end
  end

endmodule

// File: tb/tb_lbm_sweep_controller.sv
// Directed bench for lbm_sweep_controller with NODES=8, DRAIN_CYCLES=3:
// a cycle table for one full step plus hand sequences for the corner cases.
module tb_lbm_sweep_controller;

  localparam int NODES = 8;
  localparam int IDX_W = 9;
  localparam int DRAIN = 3;
  localparam logic [15:0] RD   = 16'h8000;
  localparam logic [15:0] RUN  = 16'h4000;
  localparam logic [15:0] STEP = 16'h2000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [15:0]      GPIOi = 16'h0000;
  logic             streamer_done = 1'b0;
  logic             collider_ready = 1'b1;
  logic             streamer_start;
  logic             collider_valid;
  logic [IDX_W-1:0] collider_idx;
  logic             in_collision_state;
  logic             host_rd_en;
  logic [IDX_W-1:0] host_rd_idx;
  logic             busy;
  logic [15:0]      step_count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] gpio;
    logic        done;
    logic        ready;
    logic        e_start;
    logic        e_valid;
    logic [8:0]  e_idx;
    logic        e_coll;
    logic        e_busy;
    logic [15:0] e_steps;
    logic        e_rd;
  } vec_t;

  vec_t tbl[$];

  lbm_sweep_controller #(
    .NODES        (NODES),
    .IDX_W        (IDX_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .GPIOi              (GPIOi),
    .streamer_start     (streamer_start),
    .streamer_done      (streamer_done),
    .collider_valid     (collider_valid),
    .collider_idx       (collider_idx),
    .collider_ready     (collider_ready),
    .in_collision_state (in_collision_state),
    .host_rd_en         (host_rd_en),
    .host_rd_idx        (host_rd_idx),
    .busy               (busy),
    .step_count         (step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] g, input logic d, input logic r, input logic s,
                     input logic v, input logic [8:0] i, input logic c, input logic b,
                     input logic [15:0] n, input logic h);
    vec_t t;
    t.gpio = g; t.done = d; t.ready = r; t.e_start = s; t.e_valid = v;
    t.e_idx = i; t.e_coll = c; t.e_busy = b; t.e_steps = n; t.e_rd = h;
    tbl.push_back(t);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".start"}, 32'(streamer_start), 32'd0);
    chk({tag, ".valid"}, 32'(collider_valid), 32'd0);
    chk({tag, ".idx"}, 32'(collider_idx), 32'd0);
    chk({tag, ".coll"}, 32'(in_collision_state), 32'd0);
    chk({tag, ".rd_en"}, 32'(host_rd_en), 32'd0);
    chk({tag, ".rd_idx"}, 32'(host_rd_idx), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".steps"}, 32'(step_count), 32'd0);
  endtask

  task automatic do_reset();
    GPIOi = 16'h0000; streamer_done = 1'b0; collider_ready = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for the start pulse, let the streamer take lat STREAM cycles, pulse done.
  task automatic do_stream(input int lat);
    logic found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (streamer_start) begin found = 1'b1; break; end
      tick();
    end
    chk("start_seen", 32'(found), 32'd1);
    tick();
    repeat (lat) tick();
    streamer_done = 1'b1;
    tick();
    streamer_done = 1'b0;
    chk("first_valid", 32'(collider_valid), 32'd1);
    chk("first_idx", 32'(collider_idx), 32'd0);
  endtask

  task automatic wait_steps(input int k);
    for (int i = 0; i < 200; i++) begin
      if (step_count == 16'(k)) break;
      tick();
    end
    chk("steps_reached", 32'(step_count), 32'(k));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [8:0] exp_idx;
    logic       fin;
    logic       r;
    int         starts;

    // Reset held 4 cycles, then 20 quiet cycles
    repeat (4) tick();
    chk_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 4) chk_all_zero($sformatf("idle%0d", i));
    end

    // One full step triggered by a step edge; done 5 cycles after the start pulse
    add(STEP, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(STEP, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(STEP, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(STEP, 1, 1, 0, 1, 0, 1, 1, 0, 0);
    for (int k = 1; k < NODES; k++) add(STEP, 0, 1, 0, 1, 9'(k), 1, 1, 0, 0);
    add(STEP, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(STEP, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(STEP, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(STEP, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add(STEP, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(16'h0000, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    foreach (tbl[i]) begin
      GPIOi = tbl[i].gpio; streamer_done = tbl[i].done; collider_ready = tbl[i].ready;
      tick();
      chk($sformatf("row%0d.start", i), 32'(streamer_start), 32'(tbl[i].e_start));
      chk($sformatf("row%0d.valid", i), 32'(collider_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d.idx", i), 32'(collider_idx), 32'(tbl[i].e_idx));
      chk($sformatf("row%0d.coll", i), 32'(in_collision_state), 32'(tbl[i].e_coll));
      chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d.steps", i), 32'(step_count), 32'(tbl[i].e_steps));
      chk($sformatf("row%0d.rd_en", i), 32'(host_rd_en), 32'(tbl[i].e_rd));
    end
    streamer_done = 1'b0;

    // Back-pressure: ready pattern 1,0,0,1 during COLLIDE
    GPIOi = STEP;
    do_stream(1);
    pat = 4'b1001;
    exp_idx = 9'd0;
    fin = 1'b0;
    for (int c = 0; c < 64; c++) begin
      r = pat[3 - (c % 4)];
      collider_ready = r;
      tick();
      if (r && exp_idx == 9'(NODES - 1)) begin
        fin = 1'b1;
        chk("bp_exit_valid", 32'(collider_valid), 32'd0);
        chk("bp_exit_coll", 32'(in_collision_state), 32'd1);
        break;
      end else if (r) begin
        exp_idx = exp_idx + 9'd1;
      end else begin
        exp_idx = exp_idx;
      end
      chk($sformatf("bp%0d.valid", c), 32'(collider_valid), 32'd1);
      chk($sformatf("bp%0d.idx", c), 32'(collider_idx), 32'(exp_idx));
    end
    chk("bp_finished", 32'(fin), 32'd1);
    collider_ready = 1'b1;
    wait_idle();
    chk("bp_steps", 32'(step_count), 32'd2);

    // Run for 3 steps, drop run mid-COLLIDE of step 4; done in first STREAM cycle
    do_reset();
    GPIOi = RUN;
    for (int k = 1; k <= 3; k++) begin
      do_stream(0);
      wait_steps(k);
    end
    do_stream(0);
    repeat (3) tick();
    chk("run4_in_coll", 32'(in_collision_state), 32'd1);
    GPIOi = 16'h0000;
    wait_idle();
    chk("run4_steps", 32'(step_count), 32'd4);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (streamer_start || busy) starts++;
    end
    chk("run4_stays_idle", 32'(starts), 32'd0);

    // Host read held off during the step, granted one cycle after HOLD entry
    do_reset();
    GPIOi = STEP;
    do_stream(1);
    GPIOi = STEP | RD | 16'd5;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (step_count != 16'd0) break;
      chk($sformatf("rd_blocked%0d", i), 32'(host_rd_en), 32'd0);
    end
    chk("rd_hold_steps", 32'(step_count), 32'd1);
    chk("rd_hold_entry", 32'(host_rd_en), 32'd0);
    tick();
    chk("rd_grant", 32'(host_rd_en), 32'd1);
    chk("rd_grant_idx", 32'(host_rd_idx), 32'd5);
    GPIOi = STEP | RD | 16'd9;
    tick();
    chk("rd_oob_en", 32'(host_rd_en), 32'd0);
    chk("rd_oob_idx", 32'(host_rd_idx), 32'd9);
    GPIOi = STEP | RD | 16'd7;
    tick();
    chk("rd_last_en", 32'(host_rd_en), 32'd1);
    GPIOi = STEP | 16'd5;
    tick();
    chk("rd_off_en", 32'(host_rd_en), 32'd0);

    // Async reset in the middle of DRAIN
    do_reset();
    GPIOi = STEP;
    do_stream(0);
    fin = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (in_collision_state && !collider_valid) begin fin = 1'b1; break; end
    end
    chk("drain_reached", 32'(fin), 32'd1);
    tick();
    chk("drain_mid_coll", 32'(in_collision_state), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    GPIOi = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
